// File: rtl/mmu_pkg.sv
`default_nettype none
// ============================================================================
// Module : mmu_pkg
// Brief  : Shared state encoding and default geometry for the MMU weight loader.
// Rev    : 1.0  initial release
// ============================================================================
package mmu_pkg;

    localparam int c_default_data_width = 16;
    localparam int c_default_rows       = 8;
    localparam int c_default_cols       = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        SHIFT  = 2'd2,
        COMMIT = 2'd3
    } wload_state_e;

endpackage
`default_nettype wire

// File: rtl/mmu_wload_buf.sv
`default_nettype none
// ============================================================================
// Module : mmu_wload_buf
// Brief  : Weight-row staging buffer, one write port and one registered read
//          port; read data returns to zero whenever no read is requested.
// Rev    : 1.0  initial release
// ============================================================================
module mmu_wload_buf #(
    parameter int WIDTH      = 128,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end else begin
            r_rd_data <= '0;
        end
    end

    assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/mmu_weight_loader.sv
`default_nettype none
// ============================================================================
// Module : mmu_weight_loader
// Brief  : Buffers one ROWS-deep weight tile, shifts it down the PE columns
//          deepest row first, then pulses commit/done after chain settle.
//          Optional: MMU_WLOAD_PERF_EN adds the stall_cnt output.
// Rev    : 1.0  initial release
// ============================================================================
module mmu_weight_loader
    import mmu_pkg::*;
#(
    parameter int DATA_WIDTH = c_default_data_width,
    parameter int ROWS       = c_default_rows,
    parameter int COLS       = c_default_cols
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [COLS*DATA_WIDTH-1:0] s_data,
    input  logic                       start,
    output logic                       w_wen,
    output logic [COLS*DATA_WIDTH-1:0] w_data,
    output logic                       commit,
    output logic                       busy,
    output logic                       done
`ifdef MMU_WLOAD_PERF_EN
    ,
    output logic [31:0]                stall_cnt
`endif
);

    localparam int c_cw = $clog2(ROWS + 1);
    localparam int c_aw = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [c_cw-1:0] c_last_row    = c_cw'(ROWS - 1);
    localparam logic [c_cw-1:0] c_commit_last = c_cw'(ROWS);
    localparam logic [c_aw-1:0] c_last_addr   = c_aw'(ROWS - 1);

    wload_state_e    r_state;
    wload_state_e    w_state_nxt;
    logic [c_cw-1:0] r_fill_cnt;
    logic [c_cw-1:0] r_shift_cnt;
    logic [c_cw-1:0] r_commit_cnt;
    logic            r_w_wen;
    logic            w_accept;
    logic [c_aw-1:0] w_rd_addr;

    assign w_accept  = s_valid && s_ready;
    // Read address walks ROWS-1 down to 0 so the deepest PE's row leaves first.
    assign w_rd_addr = c_last_addr - r_shift_cnt[c_aw-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        s_ready     = 1'b0;
        busy        = 1'b1;
        commit      = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = FILL;
                end
            end
            FILL: begin
                s_ready = 1'b1;
                if (s_valid && (r_fill_cnt == c_last_row)) begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (r_shift_cnt == c_last_row) begin
                    w_state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                if (r_commit_cnt == c_commit_last) begin
                    commit      = 1'b1;
                    done        = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill_cnt   <= '0;
            r_shift_cnt  <= '0;
            r_commit_cnt <= '0;
            r_w_wen      <= 1'b0;
        end else begin
            r_w_wen <= (r_state == SHIFT);

            if (r_state != FILL) begin
                r_fill_cnt <= '0;
            end else if (w_accept) begin
                r_fill_cnt <= r_fill_cnt + 1'b1;
            end

            if (r_state == SHIFT) begin
                r_shift_cnt <= r_shift_cnt + 1'b1;
            end else begin
                r_shift_cnt <= '0;
            end

            if (r_state == COMMIT) begin
                r_commit_cnt <= r_commit_cnt + 1'b1;
            end else begin
                r_commit_cnt <= '0;
            end
        end
    end

    assign w_wen = r_w_wen;

    // The buffer's registered read port doubles as the w_data output register.
    mmu_wload_buf #(
        .WIDTH      (COLS * DATA_WIDTH),
        .DEPTH      (ROWS),
        .ADDR_WIDTH (c_aw)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_accept),
        .wr_addr (r_fill_cnt[c_aw-1:0]),
        .wr_data (s_data),
        .rd_en   (r_state == SHIFT),
        .rd_addr (w_rd_addr),
        .rd_data (w_data)
    );

`ifdef MMU_WLOAD_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if ((r_state == FILL) && !s_valid && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire
